// File: rtl/mat_mult_pkg.sv
// Shared constants and writer state encoding for the matrix-multiply datapath.
// Used by the result FIFO and by mat_result_writer (RESULT_SAT_EN selects saturation there).
package mat_mult_pkg;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'b00,
    WR_COLLECT = 2'b01,
    WR_DONE    = 2'b10
  } wr_state_t;

  localparam int DEF_DATA_W      = 19;
  localparam int DEF_OUT_W       = 16;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_NUM_RESULTS = 16;
  localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/mat_result_fifo.sv
// Small synchronous capture FIFO; no bypass, so a pushed word is poppable one cycle later.
// clear empties the FIFO like reset; push on full without pop and pop on empty are ignored.
module result_fifo
  import mat_mult_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mat_result_writer.sv
// Captures MAC result strobes into a FIFO and writes them to sequential result-RAM addresses.
// Define RESULT_SAT_EN for signed saturation to OUT_W (adds sticky sat_flag); default truncates.
module mat_result_writer
  import mat_mult_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RESULTS = DEF_NUM_RESULTS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mac_valid,
  input  logic [DATA_W-1:0] mac_data,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OUT_W-1:0]  mem_wdata,
  output logic [ADDR_W:0]   result_count,
  output logic              write_done,
  output logic              overflow,
`ifdef RESULT_SAT_EN
  output logic              sat_flag,
`endif
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W:0] NUM_C  = (ADDR_W+1)'(NUM_RESULTS);
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(NUM_RESULTS - 1);

  wr_state_t         state;
  logic [ADDR_W:0]   push_cnt;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_clear;
  logic              collecting;
  logic              do_pop;
  logic              do_push;
  logic              drop;
  logic [OUT_W-1:0]  conv_data;

  assign state_dbg  = state;
  assign collecting = (state == WR_COLLECT);
  assign fifo_clear = (state == WR_IDLE) && start;
  assign do_pop     = collecting && !fifo_empty && mem_ready;
  // A full FIFO still accepts a push when the same cycle pops; the push budget caps one operation.
  assign do_push    = collecting && mac_valid && (push_cnt < NUM_C) && (!fifo_full || do_pop);
  assign drop       = collecting && mac_valid && !do_push;

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (fifo_clear),
    .push  (do_push),
    .pop   (do_pop),
    .din   (mac_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef RESULT_SAT_EN
  logic conv_clamp;

  // Out of range exactly when the bits above the OUT_W sign bit differ from the DATA_W sign.
  always_comb begin
    conv_data  = fifo_dout[OUT_W-1:0];
    conv_clamp = 1'b0;
    if (fifo_dout[DATA_W-1:OUT_W-1] != {(DATA_W-OUT_W+1){fifo_dout[DATA_W-1]}}) begin
      conv_clamp = 1'b1;
      conv_data  = fifo_dout[DATA_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_high_bits;

  assign unused_high_bits = ^fifo_dout[DATA_W-1:OUT_W];

  always_comb begin
    conv_data = fifo_dout[OUT_W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WR_IDLE;
      push_cnt     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      result_count <= '0;
      write_done   <= 1'b0;
      overflow     <= 1'b0;
`ifdef RESULT_SAT_EN
      sat_flag     <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        WR_IDLE: begin
          if (start) begin
            state        <= WR_COLLECT;
            push_cnt     <= '0;
            result_count <= '0;
            overflow     <= 1'b0;
`ifdef RESULT_SAT_EN
            sat_flag     <= 1'b0;
`endif
          end
        end
        WR_COLLECT: begin
          if (do_push) push_cnt <= push_cnt + 1'b1;
          if (drop)    overflow <= 1'b1;
          if (do_pop) begin
            mem_we       <= 1'b1;
            mem_addr     <= result_count[ADDR_W-1:0];
            mem_wdata    <= conv_data;
            result_count <= result_count + 1'b1;
`ifdef RESULT_SAT_EN
            if (conv_clamp) sat_flag <= 1'b1;
`endif
            if (result_count == LAST_C) begin
              state      <= WR_DONE;
              write_done <= 1'b1;
            end
          end
        end
        WR_DONE: begin
          if (!start) begin
            state      <= WR_IDLE;
            write_done <= 1'b0;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mat_result_writer.md
Name: mat_result_writer

Overview:
- Consumer end of the matrix-multiply controller's result strobe.
- Each time the controller pulses its output-valid strobe, this block captures the MAC accumulator value and queues it in a small FIFO.
- It writes queued values to sequential addresses of the output result RAM, honouring a RAM-side ready.
- When all NUM_RESULTS values are written, it raises write_done, following the same level start/done handshake as the controller.

Parameters:
- DATA_W, 19, width of MAC accumulator value.
- OUT_W, 16, width written to result RAM (equals DATA_W slice or saturated, see Optional Feature).
- ADDR_W, 4, result RAM address width.
- NUM_RESULTS, 16, results per matrix operation; must be ≤ 2**ADDR_W.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  level request; same signal that drives the controller.
- mac_valid  in  1  one-cycle result strobe (controller wireOut).
- mac_data  in  DATA_W  signed MAC accumulator, valid when mac_valid=1.
- mem_ready  in  1  RAM accepts a write this cycle.
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_W  registered write address.
- mem_wdata  out  OUT_W  registered write data.
- result_count  out  ADDR_W+1  results written so far.
- write_done  out  1  all results written.
- overflow  out  1  sticky: a strobe was dropped.

Behaviour:
- Reset (synchronous):
  - state IDLE; FIFO empty.
  - mem_we, mem_addr, mem_wdata, result_count, write_done and overflow all 0.
  - Reset mid-operation discards FIFO contents; no mem_we in the cycle after reset is sampled.
- States:
  - IDLE: mac_valid ignored. start=1 → COLLECT; on that edge clear result_count, overflow and FIFO.
  - COLLECT:
    - mac_valid=1 pushes mac_data on that edge.
    - Pop when FIFO non-empty and mem_ready=1. A pop registers mem_we=1, mem_addr=result_count[ADDR_W-1:0] and mem_wdata=converted entry, then increments result_count.
    - Each mem_we is a one-cycle pulse. mem_addr and mem_wdata hold their last values when mem_we=0.
    - Transition to DONE on the edge where result_count becomes NUM_RESULTS.
  - DONE: write_done=1 (registered). start=0 → IDLE, clearing write_done. start held high keeps DONE. mac_valid ignored.
- Latency: a strobe sampled at edge k with an empty FIFO and mem_ready=1 produces mem_we=1 after edge k+1 (2-cycle capture-to-write).
- mem_ready=0 stalls pops; FIFO contents are retained and no write is issued.
- FIFO boundaries:
  - Push with FIFO full and no pop in the same cycle: data dropped, overflow←1.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: push only. There is no bypass.
- Strobes arriving after NUM_RESULTS values have been pushed in the current operation are dropped and set overflow. A push counter is required alongside result_count.
- overflow is sticky until reset or the IDLE→COLLECT transition.
- Width conversion: mem_wdata = mac_data[OUT_W-1:0] (truncation).
- result_count never exceeds NUM_RESULTS; addresses do not wrap.

Optional Feature:
- Macro RESULT_SAT_EN.
- Defined: the signed DATA_W value is saturated to the OUT_W signed range on pop. Above 2**(OUT_W-1)-1 clamps to max; below -2**(OUT_W-1) clamps to min. An extra output sat_flag (1 bit, sticky, cleared like overflow) is set whenever a clamp occurs.
- Undefined: plain truncation, and the sat_flag port is absent.

Decomposition:
- Shared package mat_mult_pkg:
  - state encoding localparams WR_IDLE=2'b00, WR_COLLECT=2'b01, WR_DONE=2'b10.
  - default DATA_W/OUT_W/NUM_RESULTS constants, shared with the controller.
- Sub-module result_fifo: parameterised DATA_W × FIFO_DEPTH synchronous FIFO with push, pop, full, empty, and the same synchronous active-high reset. The FSM, counters and width conversion stay in the top.

Test Plan:
- Nominal: start=1, 16 strobes 8 cycles apart, data = 100×i, mem_ready=1 → 16 mem_we pulses, addr 0..15, wdata 0,100,…,1500; write_done=1 after the 16th write; overflow=0; start=0 → write_done=0 next cycle.
- Backpressure: mem_ready=0 for 20 cycles while 3 strobes arrive → no mem_we during the stall; then 3 writes in 3 consecutive cycles in order; overflow=0.
- Overflow: mem_ready=0, 5 strobes with FIFO_DEPTH=4 → overflow=1; the 5th value is never written. The same sequence with a simultaneous pop on the 5th strobe at full → overflow stays 0.
- Excess strobes: 17 strobes → only 16 writes, overflow=1, write_done=1.
- Reset mid-run: assert reset after the 5th write with 2 entries queued → next cycle mem_we=0, result_count=0, state IDLE; a new start writes again from addr 0.
- RESULT_SAT_EN defined: mac_data = 19'sh1FFFF (+131071) → wdata 16'h7FFF, sat_flag=1. mac_data = −131072 → 16'h8000. Without the macro, the same input gives wdata 16'hFFFF.
